// File: rtl/serial_digit_alu.sv
// serial_digit_alu
//   Digit-serial ALU sequencer. Operands of WORD_WIDTH bits are processed one
//   DIGIT_WIDTH slice per clock through a single narrow datapath, so an
//   operation takes NDIG = WORD_WIDTH/DIGIT_WIDTH RUN cycles.
//
//   Optional feature macro: SERIAL_ALU_FLAGS_EN adds the carry_out and zero
//   flag ports and their registers.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   start      operation request, accepted when not busy
//   cmd        0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL1, 6 SHR1, 7 reserved (result 0)
//   word1      operand A (the shifted operand for SHL1/SHR1)
//   word2      operand B (ignored for shifts)
//   busy       high while digits are being processed
//   done       one-cycle pulse when the result is complete
//   result     result word, stable from done until the next accepted start
//   carry_out  [SERIAL_ALU_FLAGS_EN] final carry or shifted-out bit
//   zero       [SERIAL_ALU_FLAGS_EN] final result == 0
//
// State table
//   IDLE | waiting for start
//   RUN  | one digit processed per clock
//   DONE | result complete; start here chains straight into RUN

module serial_digit_alu #(
    parameter int WORD_WIDTH  = 32,
    parameter int DIGIT_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2:0]            cmd,
    input  logic [WORD_WIDTH-1:0] word1,
    input  logic [WORD_WIDTH-1:0] word2,
    output logic                  busy,
    output logic                  done,
    output logic [WORD_WIDTH-1:0] result
`ifdef SERIAL_ALU_FLAGS_EN
    ,
    output logic                  carry_out,
    output logic                  zero
`endif
);

    localparam int NDIG = WORD_WIDTH / DIGIT_WIDTH;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

    localparam logic [2:0] CMD_ADD  = 3'd0;
    localparam logic [2:0] CMD_SUB  = 3'd1;
    localparam logic [2:0] CMD_AND  = 3'd2;
    localparam logic [2:0] CMD_OR   = 3'd3;
    localparam logic [2:0] CMD_XOR  = 3'd4;
    localparam logic [2:0] CMD_SHL1 = 3'd5;
    localparam logic [2:0] CMD_SHR1 = 3'd6;

    if ((WORD_WIDTH % DIGIT_WIDTH) != 0 || (WORD_WIDTH / DIGIT_WIDTH) < 2) begin : g_bad_params
        $error("serial_digit_alu: WORD_WIDTH must be a multiple of DIGIT_WIDTH with at least 2 digits");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WORD_WIDTH-1:0]  a_reg, b_reg;
    logic [2:0]             cmd_reg;
    logic [CW-1:0]          cnt;
    logic                   carry;

    logic                   accept;
    logic                   last_dig;
    logic [DIGIT_WIDTH-1:0] a_dig, b_dig, b_eff, d;
    logic [DIGIT_WIDTH:0]   sum;
    logic [DIGIT_WIDTH:0]   shl_full, shr_full;
    logic                   carry_next;
    logic [WORD_WIDTH-1:0]  result_next;

    logic [DIGIT_WIDTH-1:0] a_digs [NDIG];
    logic [DIGIT_WIDTH-1:0] b_digs [NDIG];

    for (genvar g = 0; g < NDIG; g++) begin : g_dig
        assign a_digs[g] = a_reg[g*DIGIT_WIDTH +: DIGIT_WIDTH];
        assign b_digs[g] = b_reg[g*DIGIT_WIDTH +: DIGIT_WIDTH];
    end

    assign busy   = (state == RUN);
    assign done   = (state == DONE);
    // start is only honoured outside RUN; a request during RUN is dropped.
    assign accept = start && (state != RUN);

    // SHR1 walks MSB->LSB so the shifted-out bit of each digit feeds the next lower one.
    assign last_dig = (cmd_reg == CMD_SHR1) ? (cnt == '0) : (cnt == LAST_DIG);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_dig) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        a_dig      = a_digs[cnt];
        b_dig      = b_digs[cnt];
        b_eff      = (cmd_reg == CMD_SUB) ? ~b_dig : b_dig;
        sum        = {1'b0, a_dig} + {1'b0, b_eff} + {{DIGIT_WIDTH{1'b0}}, carry};
        shl_full   = {a_dig, carry};
        shr_full   = {carry, a_dig};
        d          = '0;
        carry_next = carry;
        case (cmd_reg)
            CMD_ADD, CMD_SUB: begin
                d          = sum[DIGIT_WIDTH-1:0];
                carry_next = sum[DIGIT_WIDTH];
            end
            CMD_AND: d = a_dig & b_dig;
            CMD_OR:  d = a_dig | b_dig;
            CMD_XOR: d = a_dig ^ b_dig;
            CMD_SHL1: begin
                d          = shl_full[DIGIT_WIDTH-1:0];
                carry_next = a_dig[DIGIT_WIDTH-1];
            end
            CMD_SHR1: begin
                d          = shr_full[DIGIT_WIDTH:1];
                carry_next = a_dig[0];
            end
            default: d = '0;
        endcase

        result_next = result;
        for (int i = 0; i < NDIG; i++) begin
            if (cnt == CW'(i)) result_next[i*DIGIT_WIDTH +: DIGIT_WIDTH] = d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg     <= '0;
            b_reg     <= '0;
            cmd_reg   <= '0;
            cnt       <= '0;
            carry     <= 1'b0;
            result    <= '0;
`ifdef SERIAL_ALU_FLAGS_EN
            carry_out <= 1'b0;
            zero      <= 1'b0;
`endif
        end else if (accept) begin
            a_reg     <= word1;
            b_reg     <= word2;
            cmd_reg   <= cmd;
            cnt       <= (cmd == CMD_SHR1) ? LAST_DIG : '0;
            carry     <= (cmd == CMD_SUB);
            result    <= '0;
`ifdef SERIAL_ALU_FLAGS_EN
            carry_out <= 1'b0;
            zero      <= 1'b0;
`endif
        end else if (state == RUN) begin
            result <= result_next;
            carry  <= carry_next;
            if (!last_dig) begin
                cnt <= (cmd_reg == CMD_SHR1) ? cnt - 1'b1 : cnt + 1'b1;
            end
`ifdef SERIAL_ALU_FLAGS_EN
            if (last_dig) begin
                carry_out <= carry_next;
                zero      <= (result_next == '0);
            end
`endif
        end
    end

endmodule

// File: tb/tb_serial_digit_alu.sv
module tb_serial_digit_alu;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  cmd;
    logic [31:0] word1, word2;
    logic        busy, done;
    logic [31:0] result;

    logic        start16;
    logic [2:0]  cmd16;
    logic [15:0] a16, b16;
    logic        busy16, done16;
    logic [15:0] result16;

`ifdef SERIAL_ALU_FLAGS_EN
    logic carry_out, zero, carry_out16, zero16;
`endif

    int checks   = 0;
    int failures = 0;

    serial_digit_alu #(.WORD_WIDTH(32), .DIGIT_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .start(start), .cmd(cmd),
        .word1(word1), .word2(word2),
        .busy(busy), .done(done), .result(result)
`ifdef SERIAL_ALU_FLAGS_EN
        , .carry_out(carry_out), .zero(zero)
`endif
    );

    serial_digit_alu #(.WORD_WIDTH(16), .DIGIT_WIDTH(8)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .cmd(cmd16),
        .word1(a16), .word2(b16),
        .busy(busy16), .done(done16), .result(result16)
`ifdef SERIAL_ALU_FLAGS_EN
        , .carry_out(carry_out16), .zero(zero16)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string       name;
        logic [2:0]  cmd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        cout;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Leaves the bench at the falling edge right after the accept edge.
    task automatic start_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        cmd   = c;
        word1 = a;
        word2 = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n;
        int pulses;

        vecs[0]  = '{"add_efffffff",  3'd0, 32'hefff_ffff, 32'h0000_0001, 32'hf000_0000, 1'b0};
        vecs[1]  = '{"add_ffffffff",  3'd0, 32'hffff_ffff, 32'h0000_0001, 32'h0000_0000, 1'b1};
        vecs[2]  = '{"sub_5_7",       3'd1, 32'h0000_0005, 32'h0000_0007, 32'hffff_fffe, 1'b0};
        vecs[3]  = '{"sub_7_5",       3'd1, 32'h0000_0007, 32'h0000_0005, 32'h0000_0002, 1'b1};
        vecs[4]  = '{"shr1_06000000", 3'd6, 32'h0600_0000, 32'hdead_beef, 32'h0300_0000, 1'b0};
        vecs[5]  = '{"shl1_80000001", 3'd5, 32'h8000_0001, 32'hdead_beef, 32'h0000_0002, 1'b1};
        vecs[6]  = '{"xor",           3'd4, 32'hf0f0_f0f0, 32'hffff_0000, 32'h0f0f_f0f0, 1'b0};
        vecs[7]  = '{"and",           3'd2, 32'h1234_5678, 32'h0f0f_0f0f, 32'h0204_0608, 1'b0};
        vecs[8]  = '{"or",            3'd3, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0};
        vecs[9]  = '{"cmd7",          3'd7, 32'hffff_ffff, 32'hffff_ffff, 32'h0000_0000, 1'b0};
        vecs[10] = '{"shr1_00000001", 3'd6, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[11] = '{"sub_0_0",       3'd1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1};

        reset   = 1'b1;
        start   = 1'b0;
        cmd     = 3'd0;
        word1   = '0;
        word2   = '0;
        start16 = 1'b0;
        cmd16   = 3'd0;
        a16     = '0;
        b16     = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("reset_busy",   {31'd0, busy},   32'd0);
        check("reset_done",   {31'd0, done},   32'd0);
        check("reset_result", result,          32'd0);
`ifdef SERIAL_ALU_FLAGS_EN
        check("reset_carry_out", {31'd0, carry_out}, 32'd0);
        check("reset_zero",      {31'd0, zero},      32'd0);
`endif

        for (int i = 0; i < 12; i++) begin
            start_op(vecs[i].cmd, vecs[i].a, vecs[i].b);
            check({vecs[i].name, "_busy"}, {31'd0, busy}, 32'd1);
            wait_done(n);
            check({vecs[i].name, "_latency"}, 32'(n), 32'd8);
            check({vecs[i].name, "_result"}, result, vecs[i].res);
`ifdef SERIAL_ALU_FLAGS_EN
            check({vecs[i].name, "_carry_out"}, {31'd0, carry_out}, {31'd0, vecs[i].cout});
            check({vecs[i].name, "_zero"}, {31'd0, zero}, {31'd0, (vecs[i].res == 32'd0)});
`endif
            @(negedge clk);
            check({vecs[i].name, "_done_pulse"}, {31'd0, done}, 32'd0);
            check({vecs[i].name, "_hold"}, result, vecs[i].res);
        end

        // start and operand changes while RUN are ignored
        start_op(3'd0, 32'h0000_0001, 32'h0000_0002);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        word1 = 32'hffff_ffff;
        cmd   = 3'd1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        check("ignore_latency", 32'(n + 3), 32'd8);
        check("ignore_result", result, 32'h0000_0003);
        @(negedge clk);
        check("ignore_no_requeue", {31'd0, busy}, 32'd0);

        // reset during RUN aborts without a done pulse
        start_op(3'd0, 32'h1111_1111, 32'h2222_2222);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy",   {31'd0, busy}, 32'd0);
        check("abort_result", result,        32'd0);
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        check("abort_no_done", 32'(pulses), 32'd0);
        check("abort_result_held", result, 32'd0);

        // reset and start on the same edge: start is dropped
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        cmd   = 3'd0;
        word1 = 32'h0000_0003;
        word2 = 32'h0000_0004;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check("rst_start_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("rst_start_busy_after", {31'd0, busy}, 32'd0);

        // start held through DONE chains the next op with no IDLE gap
        @(negedge clk);
        cmd   = 3'd0;
        word1 = 32'h0000_0001;
        word2 = 32'h0000_0001;
        start = 1'b1;
        @(negedge clk);
        word1 = 32'h0000_0005;
        word2 = 32'h0000_0006;
        wait_done(n);
        check("b2b_first_latency", 32'(n), 32'd8);
        check("b2b_first_result", result, 32'h0000_0002);
        @(negedge clk);
        start = 1'b0;
        check("b2b_no_gap_busy", {31'd0, busy}, 32'd1);
        check("b2b_no_gap_done", {31'd0, done}, 32'd0);
        check("b2b_result_cleared", result, 32'd0);
        wait_done(n);
        check("b2b_second_latency", 32'(n), 32'd8);
        check("b2b_second_result", result, 32'h0000_000b);

        // 16-bit word, 8-bit digits
        @(negedge clk);
        cmd16   = 3'd0;
        a16     = 16'h00ff;
        b16     = 16'h0001;
        start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        n = 0;
        while (done16 !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("w16_latency", 32'(n), 32'd2);
        check("w16_result", {16'd0, result16}, 32'h0000_0100);
`ifdef SERIAL_ALU_FLAGS_EN
        check("w16_carry_out", {31'd0, carry_out16}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
